ptw_mem_arbiter: RTL and testbench

Shares one page-table-walk memory read port between the instruction-side MMU (inside the IFU) and the data-side MMU (inside the LSU).
- Each MMU presents a level-held request (req + addr) and expects a single-cycle rvalid/rdata response, one walk level at a time.
- The arbiter picks an owner, issues a valid/ready request to memory and routes the response back to the owner.
- If the owner is flushed while its access is outstanding, the response is swallowed.

---
 rtl/ptw_mem_arbiter.sv | 78 +++++++
 tb/tb_ptw_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter: shares one page-table-walk memory read port between the I-MMU and D-MMU.
// One access outstanding at a time; a response is swallowed when its owner is flushed mid-access.
module ptw_mem_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_mem_req_i,
    input  logic [AW-1:0] i_mem_addr_i,
    input  logic          i_flush_i,
    output logic [DW-1:0] i_mem_rdata_o,
    output logic          i_mem_rvalid_o,
    input  logic          d_mem_req_i,
    input  logic [AW-1:0] d_mem_addr_i,
    input  logic          d_flush_i,
    output logic [DW-1:0] d_mem_rdata_o,
    output logic          d_mem_rvalid_o,
    output logic          mem_req_valid_o,
    output logic [AW-1:0] mem_req_addr_o,
    input  logic          mem_req_ready_i,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_rvalid_i,
    output logic          busy_o,
    output logic          owner_d_o
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;

    logic [1:0] state;
    logic       owner_d, last_d, drop;
    logic       i_elig, d_elig, grant_d, own_flush, done, resp;

    always_comb begin
        i_elig    = i_mem_req_i & ~i_flush_i;
        d_elig    = d_mem_req_i & ~d_flush_i;
        grant_d   = (i_elig & d_elig) ? ((PRIO_MODE != 0) | ~last_d) : d_elig;
        own_flush = owner_d ? d_flush_i : i_flush_i;
        done      = (state == WAIT) & mem_req_ready_i & mem_rvalid_i;
        // a flush arriving with the data still kills that response
        resp      = done & ~drop & ~own_flush;
    end

    assign mem_req_valid_o = state == REQ;
    assign busy_o          = state != IDLE;
    assign owner_d_o       = owner_d;
    assign i_mem_rvalid_o  = resp & ~owner_d;
    assign d_mem_rvalid_o  = resp & owner_d;
    assign i_mem_rdata_o   = i_mem_rvalid_o ? mem_rdata_i : '0;
    assign d_mem_rdata_o   = d_mem_rvalid_o ? mem_rdata_i : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            owner_d        <= 1'b1;
            last_d         <= 1'b1;
            drop           <= 1'b0;
            mem_req_addr_o <= '0;
        end else if (state == IDLE) begin
            if (i_elig | d_elig) begin
                state          <= REQ;
                owner_d        <= grant_d;
                mem_req_addr_o <= grant_d ? d_mem_addr_i : i_mem_addr_i;
            end
        end else if (state == REQ) begin
            drop <= drop | own_flush;
            if (mem_req_ready_i) begin
                state  <= WAIT;
                last_d <= owner_d;
            end
        end else if (done) begin
            state <= IDLE;
            drop  <= 1'b0;
        end else begin
            drop <= drop | own_flush;
        end
    end
endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// tb_ptw_mem_arbiter: round-robin and D-priority instances driven in parallel, checked
// every cycle against a transaction-level reference model, plus directed scenarios.
module tb_ptw_mem_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        i_req = 0, i_flush = 0, d_req = 0, d_flush = 0;
    logic [31:0] i_addr = 0, d_addr = 0, rdata = 0;
    logic        ready = 0, rvalid = 0;
    logic        valid [2], irv [2], drv [2], busy [2], own [2];
    logic [31:0] addr [2], ird [2], drd [2];
    int          passed = 0, total = 0, failed = 0;
    bit          m_act [2], m_acc [2], m_d [2], m_last [2], m_drop [2];
    logic [31:0] m_addr [2];
    bit          r_i, r_d;

    always #5 clk = ~clk;

    ptw_mem_arbiter #(.PRIO_MODE(0)) u0 (
        .clk(clk), .rst(rst),
        .i_mem_req_i(i_req), .i_mem_addr_i(i_addr), .i_flush_i(i_flush),
        .i_mem_rdata_o(ird[0]), .i_mem_rvalid_o(irv[0]),
        .d_mem_req_i(d_req), .d_mem_addr_i(d_addr), .d_flush_i(d_flush),
        .d_mem_rdata_o(drd[0]), .d_mem_rvalid_o(drv[0]),
        .mem_req_valid_o(valid[0]), .mem_req_addr_o(addr[0]), .mem_req_ready_i(ready),
        .mem_rdata_i(rdata), .mem_rvalid_i(rvalid), .busy_o(busy[0]), .owner_d_o(own[0]));

    ptw_mem_arbiter #(.PRIO_MODE(1)) u1 (
        .clk(clk), .rst(rst),
        .i_mem_req_i(i_req), .i_mem_addr_i(i_addr), .i_flush_i(i_flush),
        .i_mem_rdata_o(ird[1]), .i_mem_rvalid_o(irv[1]),
        .d_mem_req_i(d_req), .d_mem_addr_i(d_addr), .d_flush_i(d_flush),
        .d_mem_rdata_o(drd[1]), .d_mem_rvalid_o(drv[1]),
        .mem_req_valid_o(valid[1]), .mem_req_addr_o(addr[1]), .mem_req_ready_i(ready),
        .mem_rdata_i(rdata), .mem_rvalid_i(rvalid), .busy_o(busy[1]), .owner_d_o(own[1]));

    task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_acc[k] = 0; m_d[k] = 1; m_last[k] = 1; m_drop[k] = 0; m_addr[k] = 0;
        end
    endtask

    // Expected outputs for the present cycle given model state and current inputs
    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit fl, resp;
            fl   = m_d[k] ? d_flush : i_flush;
            resp = m_act[k] && m_acc[k] && ready && rvalid && !m_drop[k] && !fl;
            chk("valid", k, 64'(valid[k]), 64'(m_act[k] && !m_acc[k]));
            chk("addr", k, 64'(addr[k]), 64'(m_addr[k]));
            chk("busy", k, 64'(busy[k]), 64'(m_act[k]));
            chk("owner_d", k, 64'(own[k]), 64'(m_d[k]));
            chk("i_rvalid", k, 64'(irv[k]), 64'(resp && !m_d[k]));
            chk("d_rvalid", k, 64'(drv[k]), 64'(resp && m_d[k]));
            chk("i_rdata", k, 64'(ird[k]), (resp && !m_d[k]) ? 64'(rdata) : 64'd0);
            chk("d_rdata", k, 64'(drd[k]), (resp && m_d[k]) ? 64'(rdata) : 64'd0);
            if (k == 0) begin
                r_i = resp && !m_d[k];
                r_d = resp && m_d[k];
            end
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            bit ei, ed, g, fl;
            ei = i_req && !i_flush;
            ed = d_req && !d_flush;
            fl = m_d[k] ? d_flush : i_flush;
            if (!m_act[k]) begin
                if (ei || ed) begin
                    g = (ei && ed) ? (k == 1 || !m_last[k]) : ed;
                    m_act[k] = 1; m_acc[k] = 0; m_d[k] = g;
                    m_addr[k] = g ? d_addr : i_addr;
                end
            end else if (m_acc[k] && ready && rvalid) begin
                m_act[k] = 0; m_drop[k] = 0;
            end else begin
                if (fl) m_drop[k] = 1;
                if (!m_acc[k] && ready) begin m_acc[k] = 1; m_last[k] = m_d[k]; end
            end
        end
    endtask

    task automatic tick(); @(negedge clk); check_all(); endtask
    task automatic adv(); @(posedge clk); if (!rst) model_update(); #1; endtask
    task automatic step(); tick(); adv(); endtask

    task automatic drain();
        i_req = 0; d_req = 0; i_flush = 0; d_flush = 0; ready = 1; rvalid = 1;
        repeat (4) step();
        rvalid = 0;
    endtask

    initial begin
        logic exp_seq [4];
        int n;
        model_reset();
        step(); step();
        rst = 0;
        step();

        // single I walk
        i_req = 1; i_addr = 32'h8000_1004; ready = 1;
        step(); step(); step(); step();
        rvalid = 1; rdata = 32'h2000_0C01;
        tick();
        chk("walk_irv", 0, 64'(irv[0]), 64'd1);
        chk("walk_data", 0, 64'(ird[0]), 64'h2000_0C01);
        chk("walk_addr", 0, 64'(addr[0]), 64'h8000_1004);
        chk("walk_drv", 0, 64'(drv[0]), 64'd0);
        adv();
        i_req = 0; rvalid = 0;
        tick();
        chk("walk_busy", 0, 64'(busy[0]), 64'd0);
        adv();

        // backpressure on D
        d_req = 1; d_addr = 32'h0000_4ABC; ready = 0;
        step();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid", 0, 64'(valid[0]), 64'd1);
            chk("bp_addr", 0, 64'(addr[0]), 64'h0000_4ABC);
            adv();
        end
        ready = 1;
        tick();
        chk("bp_hs", 0, 64'(valid[0]), 64'd1);
        adv();
        tick();
        chk("bp_wait", 0, 64'(valid[0]), 64'd0);
        adv();
        drain();

        // flush drop on D
        d_req = 1; d_addr = 32'h0000_7000; ready = 1;
        step(); step();
        d_flush = 1; step();
        d_flush = 0; d_req = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
        tick();
        chk("drop_drv", 0, 64'(drv[0]), 64'd0);
        adv();
        rvalid = 0; i_req = 1; i_addr = 32'h8000_2000;
        step();
        tick();
        chk("after_drop_owner", 0, 64'(own[0]), 64'd0);
        chk("after_drop_addr", 0, 64'(addr[0]), 64'h8000_2000);
        adv();
        drain();

        // async reset while in WAIT
        d_req = 1; d_addr = 32'h0000_1234; ready = 1;
        step(); step();
        d_req = 0;
        #2 rst = 1;
        #1;
        model_reset();
        chk("rst_busy", 0, 64'(busy[0]), 64'd0);
        chk("rst_owner", 0, 64'(own[0]), 64'd1);
        chk("rst_addr", 0, 64'(addr[0]), 64'd0);
        check_all();
        adv();
        rst = 0;

        // contention: RR gives I,D,I,D; D-priority keeps D
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
        n = 0;
        i_req = 1; d_req = 1; i_addr = 32'h8000_3000; d_addr = 32'h0000_9000; rvalid = 1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (valid[0] && n < 4) begin chk("rr_owner", n, 64'(own[0]), 64'(exp_seq[n])); n++; end
            if (valid[1]) chk("prio_owner", c, 64'(own[1]), 64'd1);
            adv();
        end
        chk("rr_count", 0, 64'(n), 64'd4);
        d_req = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (valid[1] && c > 2) chk("prio_i_served", c, 64'(own[1]), 64'd0);
            adv();
        end
        drain();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            ready   = $urandom_range(1, 0);
            rvalid  = ($urandom_range(2, 0) == 0);
            rdata   = $urandom;
            i_flush = ($urandom_range(15, 0) == 0);
            d_flush = ($urandom_range(15, 0) == 0);
            if (!i_req) begin
                if ($urandom_range(2, 0) == 0) begin i_req = 1; i_addr = $urandom; end
            end else if (r_i) begin
                if ($urandom_range(1, 0) == 0) i_req = 0; else i_addr = $urandom;
            end else if (i_flush && $urandom_range(1, 0) == 0) i_req = 0;
            if (!d_req) begin
                if ($urandom_range(2, 0) == 0) begin d_req = 1; d_addr = $urandom; end
            end else if (r_d) begin
                if ($urandom_range(1, 0) == 0) d_req = 0; else d_addr = $urandom;
            end else if (d_flush && $urandom_range(1, 0) == 0) d_req = 0;
            step();
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
